caliptra_fpga_gpio_log: RTL and testbench
=========================================

CALIPTRA_FPGA_GPIO_LOG -- requirements
Module: caliptra_fpga_gpio_log

Interface
REQ-001: Parameter DEPTH, default 32, number of log entries; SHALL be a power of two, minimum 2.
REQ-002: Parameter TS_W, default 32, width of the timestamp stored per entry.
REQ-003: aclk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: sample_en  input  1  high on cycles where the gated Caliptra clock ticks; the block samples inputs only then.
REQ-006: wires_in  input  64  Caliptra generic_output_wires.
REQ-007: timestamp  input  64  free-running gated-cycle counter; the low TS_W bits are logged.
REQ-008: pop  input  1  single-cycle strobe from the register block; consumes the head entry.
REQ-009: clear  input  1  single-cycle strobe; flushes the log and error state.
REQ-010: out_valid  output  1  head entry present (log not empty).
REQ-011: out_value  output  64  wires value of the head entry.
REQ-012: out_ts  output  TS_W  timestamp of the head entry.
REQ-013: level  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014: overflow  output  1  sticky flag: at least one change was dropped.
REQ-015: drop_count  output  16  number of dropped changes, saturating.

Function
REQ-016: Register prev SHALL load wires_in on every cycle with sample_en=1, and hold otherwise.
REQ-017: A change event SHALL be detected when sample_en=1 and wires_in != prev.
REQ-018: On a change event with the log not full, the block SHALL push {wires_in, timestamp[TS_W-1:0]}; level SHALL rise by 1 on the next cycle.
REQ-019: On a change event with the log full and no pop in the same cycle, the event SHALL be dropped, overflow SHALL be set, and drop_count SHALL increment, saturating at 16'hFFFF.
REQ-020: A change event coincident with pop while full SHALL be accepted; level SHALL stay DEPTH and SHALL not count as a drop.
REQ-021: pop with level=0 SHALL be ignored; no state SHALL change.
REQ-022: A push and pop in the same cycle with 0<level<DEPTH SHALL leave level unchanged.
REQ-023: Output is show-ahead: out_value/out_ts SHALL present the head entry whenever out_valid=1; after pop, the next entry SHALL appear on the following cycle.
REQ-024: out_value/out_ts SHALL be 0 whenever out_valid=0.
REQ-025: Read/write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-026: clear SHALL have priority over push and pop in the same cycle: it empties the log and zeroes overflow and drop_count; it SHALL not modify prev.
REQ-027: out_valid SHALL equal (level != 0), derived from registered state only.

Reset
REQ-028: On rst: pointers=0, level=0, out_valid=0, out_value=0, out_ts=0, overflow=0, drop_count=0, prev=0.
REQ-029: Reset asserted mid-operation SHALL discard all entries immediately; the first sample_en after release with wires_in != 0 SHALL log an entry.
REQ-030: Log storage contents need no reset.

Structure
REQ-031: Package caliptra_fpga_gpio_log_pkg SHALL hold the entry struct typedef (value 64, ts TS_W default) and the constant DROP_CNT_W=16.
REQ-032: Storage and pointer logic SHALL be a sub-module caliptra_fpga_log_fifo (synchronous, show-ahead, width/depth parameters); change detection and error counters SHALL be in the top.
REQ-033: The memory array SHALL be inferable as distributed RAM.

Verification
REQ-034: After reset, wires_in=0x1 with sample_en=1 at timestamp=100 -> next cycle level=1, out_valid=1, out_value=0x1, out_ts=100.
REQ-035: wires_in changes 0x1->0x3 with sample_en=0 for 5 cycles, then sample_en=1 -> exactly one entry, value 0x3.
REQ-036: DEPTH=32: 34 distinct changes without pop -> level=32, overflow=1, drop_count=2, head value = first change.
REQ-037: Log full, change event and pop in the same cycle -> level=32, drop_count unchanged, new entry is last in order.
REQ-038: Force drop_count to 0xFFFF, cause one more drop -> drop_count stays 0xFFFF; then clear with a simultaneous change -> level=0, overflow=0, drop_count=0, change not logged.
REQ-039: 3 entries, pop 4 times on consecutive cycles -> values returned in order, level=0, 4th pop ignored, out_value=0.

Source files
------------

// File: rtl/caliptra_fpga_gpio_log_pkg.sv
// rtl/caliptra_fpga_gpio_log_pkg.sv - shared types and constants for the GPIO change log
//
// Purpose: default log-entry layout, drop-counter width and the saturating
//          increment used by the drop counter.
// Ports:   none (package)
package caliptra_fpga_gpio_log_pkg;

  localparam int DROP_CNT_W   = 16;
  localparam int VALUE_W      = 64;
  localparam int TS_W_DEFAULT = 32;

  // Entry layout as stored in the log: wires value in the upper bits,
  // timestamp in the lower bits.
  typedef struct packed {
    logic [VALUE_W-1:0]      value;
    logic [TS_W_DEFAULT-1:0] ts;
  } log_entry_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/caliptra_fpga_log_fifo.sv
// rtl/caliptra_fpga_log_fifo.sv - synchronous show-ahead FIFO holding log entries
//
// Purpose: entry storage and pointer/level bookkeeping for the GPIO change log.
// Ports:
//   aclk, rst     clock, asynchronous active-high reset
//   clr           flush; wins over push and pop in the same cycle
//   push, din     write request and data; accepted when not full, or when
//                 full together with a valid pop
//   pop           consume head entry; ignored when empty
//   dout          head entry (show-ahead), zero when empty
//   level         number of stored entries
//   full, empty   level == DEPTH / level == 0
module caliptra_fpga_log_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 32
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // No reset on the array so it maps onto distributed RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));

  assign do_pop  = pop && !empty && !clr;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && !clr && (!full || do_pop);

  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are PTR_W bits wide and wrap modulo DEPTH (power of two).
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign level = level_q;

endmodule

// File: rtl/caliptra_fpga_gpio_log.sv
// rtl/caliptra_fpga_gpio_log.sv - change log of Caliptra generic_output_wires
//
// Purpose: records every change of wires_in (sampled on gated-clock ticks)
//          with a timestamp into a FIFO; counts changes dropped while full.
// Ports:
//   aclk, rst            clock, asynchronous active-high reset
//   sample_en            gated Caliptra clock tick; inputs sampled only then
//   wires_in, timestamp  monitored wires and gated-cycle counter
//   pop, clear           register-block strobes: consume head / flush all
//   out_valid, out_value, out_ts   show-ahead head entry (zero when empty)
//   level                stored entry count
//   overflow, drop_count sticky drop flag and saturating drop counter
module caliptra_fpga_gpio_log
  import caliptra_fpga_gpio_log_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int TS_W  = 32
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [63:0]             wires_in,
  input  logic [63:0]             timestamp,
  input  logic                    pop,
  input  logic                    clear,
  output logic                    out_valid,
  output logic [63:0]             out_value,
  output logic [TS_W-1:0]         out_ts,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  localparam int ENTRY_W = VALUE_W + TS_W;

  logic [63:0]            prev;
  logic                   change;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;
  logic [ENTRY_W-1:0]     fifo_dout;
  logic                   overflow_q;
  logic [DROP_CNT_W-1:0]  drop_count_q;

  generate
    if (TS_W < 64) begin : g_ts_upper
      logic unused_ts_upper;
      assign unused_ts_upper = ^timestamp[63:TS_W];
    end
  endgenerate

  // clear does not touch prev: prev tracks the wires, not the log.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      prev <= '0;
    end else if (sample_en) begin
      prev <= wires_in;
    end
  end

  assign change = sample_en && (wires_in != prev);

  // A pop while full frees the slot for this cycle's change, so it is not a drop.
  assign drop = change && fifo_full && !pop && !clear;

  caliptra_fpga_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk  (aclk),
    .rst   (rst),
    .clr   (clear),
    .push  (change),
    .din   ({wires_in, timestamp[TS_W-1:0]}),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (clear) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q   <= 1'b1;
      drop_count_q <= sat_inc(drop_count_q);
    end
  end

  // FIFO already returns zero when empty, so the outputs follow suit.
  assign out_valid  = !fifo_empty;
  assign out_value  = fifo_dout[ENTRY_W-1:TS_W];
  assign out_ts     = fifo_dout[TS_W-1:0];
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_caliptra_fpga_gpio_log.sv
// tb/tb_caliptra_fpga_gpio_log.sv - directed self-checking bench for caliptra_fpga_gpio_log
module tb_caliptra_fpga_gpio_log;

  logic        aclk;
  logic        rst;
  logic        sample_en;
  logic [63:0] wires_in;
  logic [63:0] timestamp;
  logic        pop;
  logic        clear;
  logic        out_valid;
  logic [63:0] out_value;
  logic [31:0] out_ts;
  logic [5:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int total;
  int bad;

  caliptra_fpga_gpio_log #(.DEPTH(32), .TS_W(32)) dut (
    .aclk       (aclk),
    .rst        (rst),
    .sample_en  (sample_en),
    .wires_in   (wires_in),
    .timestamp  (timestamp),
    .pop        (pop),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_value  (out_value),
    .out_ts     (out_ts),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic cycle();
    @(negedge aclk);
  endtask

  // One sampled change; inputs driven at negedge, result visible next negedge.
  task automatic change_to(input logic [63:0] v, input logic [63:0] ts);
    wires_in  = v;
    timestamp = ts;
    sample_en = 1'b1;
    cycle();
    sample_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    total++;
    if (level !== 6'd0 || out_valid !== 1'b0 || out_value !== 64'd0 || out_ts !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: level=%0d valid=%0b value=%h ts=%0d, want 0/0/0/0", level, out_valid, out_value, out_ts);
    end
    total++;
    if (overflow !== 1'b0 || drop_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_errors: overflow=%0b drop=%0d, want 0/0", overflow, drop_count);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_first_entry();
    change_to(64'h1, 64'd100);
    total++;
    if (level !== 6'd1 || out_valid !== 1'b1 || out_value !== 64'h1 || out_ts !== 32'd100) begin
      bad++;
      $display("FAIL first_entry: level=%0d valid=%0b value=%h ts=%0d, want 1/1/1/100", level, out_valid, out_value, out_ts);
    end
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    total++;
    if (level !== 6'd0 || out_valid !== 1'b0 || out_value !== 64'd0) begin
      bad++;
      $display("FAIL first_pop: level=%0d valid=%0b value=%h, want 0/0/0", level, out_valid, out_value);
    end
  endtask

  task automatic test_gated();
    wires_in  = 64'h3;
    sample_en = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    total++;
    if (level !== 6'd0) begin
      bad++;
      $display("FAIL gated_no_sample: level=%0d, want 0", level);
    end
    change_to(64'h3, 64'd200);
    sample_en = 1'b1;
    cycle();
    cycle();
    sample_en = 1'b0;
    total++;
    if (level !== 6'd1 || out_value !== 64'h3 || out_ts !== 32'd200) begin
      bad++;
      $display("FAIL gated_one_entry: level=%0d value=%h ts=%0d, want 1/3/200", level, out_value, out_ts);
    end
    pop = 1'b1;
    cycle();
    pop = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 34; i++) change_to(64'h100 + 64'(i), 64'd1000 + 64'(i));
    total++;
    if (level !== 6'd32 || overflow !== 1'b1 || drop_count !== 16'd2) begin
      bad++;
      $display("FAIL overflow_state: level=%0d overflow=%0b drop=%0d, want 32/1/2", level, overflow, drop_count);
    end
    total++;
    if (out_value !== 64'h100 || out_ts !== 32'd1000) begin
      bad++;
      $display("FAIL overflow_head: value=%h ts=%0d, want 100/1000", out_value, out_ts);
    end
  endtask

  task automatic test_pop_full();
    logic [63:0] exp;
    pop = 1'b1;
    change_to(64'h200, 64'd2000);
    pop = 1'b0;
    total++;
    if (level !== 6'd32 || drop_count !== 16'd2 || out_value !== 64'h101) begin
      bad++;
      $display("FAIL pop_full_push: level=%0d drop=%0d head=%h, want 32/2/101", level, drop_count, out_value);
    end
    for (int i = 0; i < 32; i++) begin
      exp = (i < 31) ? 64'h101 + 64'(i) : 64'h200;
      total++;
      if (out_value !== exp || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL drain_order[%0d]: value=%h valid=%0b, want %h/1", i, out_value, out_valid, exp);
      end
      pop = 1'b1;
      cycle();
      pop = 1'b0;
    end
    total++;
    if (level !== 6'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: level=%0d valid=%0b, want 0/0", level, out_valid);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 32; i++) change_to(64'h300 + 64'(i), 64'd3000 + 64'(i));
    total++;
    if (level !== 6'd32) begin
      bad++;
      $display("FAIL refill_level: level=%0d, want 32", level);
    end
    force dut.drop_count_q = 16'hFFFE;
    cycle();
    release dut.drop_count_q;
    change_to(64'h350, 64'd3500);
    total++;
    if (drop_count !== 16'hFFFF || overflow !== 1'b1) begin
      bad++;
      $display("FAIL sat_reach: drop=%h overflow=%0b, want ffff/1", drop_count, overflow);
    end
    change_to(64'h351, 64'd3501);
    total++;
    if (drop_count !== 16'hFFFF || level !== 6'd32) begin
      bad++;
      $display("FAIL sat_hold: drop=%h level=%0d, want ffff/32", drop_count, level);
    end
    clear = 1'b1;
    change_to(64'h400, 64'd4000);
    clear = 1'b0;
    total++;
    if (level !== 6'd0 || overflow !== 1'b0 || drop_count !== 16'd0 || out_valid !== 1'b0 || out_value !== 64'd0) begin
      bad++;
      $display("FAIL clear_with_change: level=%0d ovf=%0b drop=%0d valid=%0b value=%h, want all 0", level, overflow, drop_count, out_valid, out_value);
    end
    change_to(64'h400, 64'd4001);
    total++;
    if (level !== 6'd0) begin
      bad++;
      $display("FAIL clear_change_not_logged: level=%0d, want 0", level);
    end
  endtask

  task automatic test_back_to_back();
    change_to(64'hA5, 64'd5000);
    pop = 1'b1;
    change_to(64'h5A, 64'd5001);
    pop = 1'b0;
    total++;
    if (level !== 6'd1 || out_value !== 64'h5A || out_ts !== 32'd5001) begin
      bad++;
      $display("FAIL push_pop_mid: level=%0d value=%h ts=%0d, want 1/5a/5001", level, out_value, out_ts);
    end
    pop = 1'b1;
    cycle();
    pop = 1'b0;
  endtask

  task automatic test_pop_empty();
    logic [63:0] exp_v [4];
    logic [5:0]  exp_l [4];
    exp_v = '{64'hB, 64'hC, 64'h0, 64'h0};
    exp_l = '{6'd2, 6'd1, 6'd0, 6'd0};
    change_to(64'hA, 64'd10);
    change_to(64'hB, 64'd11);
    change_to(64'hC, 64'd12);
    total++;
    if (level !== 6'd3 || out_value !== 64'hA || out_ts !== 32'd10) begin
      bad++;
      $display("FAIL three_entries: level=%0d value=%h ts=%0d, want 3/a/10", level, out_value, out_ts);
    end
    pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if (level !== exp_l[i] || out_value !== exp_v[i] || out_valid !== (exp_l[i] != 0)) begin
        bad++;
        $display("FAIL pop_seq[%0d]: level=%0d value=%h valid=%0b, want %0d/%h", i, level, out_value, out_valid, exp_l[i], exp_v[i]);
      end
    end
    pop = 1'b0;
    total++;
    if (out_ts !== 32'd0) begin
      bad++;
      $display("FAIL pop_empty_ts: ts=%0d, want 0", out_ts);
    end
  endtask

  task automatic test_reset_mid();
    change_to(64'h77, 64'd20);
    change_to(64'h78, 64'd21);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (level !== 6'd0 || out_valid !== 1'b0 || out_value !== 64'd0) begin
      bad++;
      $display("FAIL async_reset: level=%0d valid=%0b value=%h, want 0/0/0", level, out_valid, out_value);
    end
    cycle();
    rst = 1'b0;
    change_to(64'h78, 64'd22);
    total++;
    if (level !== 6'd1 || out_value !== 64'h78 || out_ts !== 32'd22) begin
      bad++;
      $display("FAIL post_reset_entry: level=%0d value=%h ts=%0d, want 1/78/22", level, out_value, out_ts);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    sample_en = 1'b0;
    wires_in  = 64'd0;
    timestamp = 64'd0;
    pop       = 1'b0;
    clear     = 1'b0;
    test_reset();
    test_first_entry();
    test_gated();
    test_overflow();
    test_pop_full();
    test_saturate();
    test_back_to_back();
    test_pop_empty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
